// File: rtl/button_bank_debouncer.sv
// Multi-channel push-button debouncer: two-flop synchronizer, stability counter,
// edge pulses and optional auto-repeat per channel.
module button_bank_debouncer #(
  parameter int CHANNELS     = 4,
  parameter int STABLE_TICKS = 20,
  parameter int PRESS_LEVEL  = 0,
  parameter int REPEAT_EN    = 0,
  parameter int REPEAT_DELAY = 1000,
  parameter int REPEAT_RATE  = 200
) (
  input  logic                i_Clk,
  input  logic                i_Reset,
  input  logic [CHANNELS-1:0] i_Button,
  output logic [CHANNELS-1:0] o_ButtonDeb,
  output logic [CHANNELS-1:0] o_ButtonDown,
  output logic [CHANNELS-1:0] o_ButtonUp,
  output logic [CHANNELS-1:0] o_Repeat
);

  localparam int              CNT_W    = $clog2(STABLE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);
  localparam logic            PRESS    = (PRESS_LEVEL != 0);
  localparam logic            IDLE     = ~PRESS;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic             meta_q, sync_q;
      logic             deb_q, deb_d;
      logic             down_q, down_d;
      logic             up_q, up_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             accept;

      // A level change is taken only after STABLE_TICKS consecutive differing samples.
      always_comb begin
        deb_d  = deb_q;
        cnt_d  = '0;
        down_d = 1'b0;
        up_d   = 1'b0;
        accept = 1'b0;
        if (sync_q != deb_q) begin
          if (cnt_q == CNT_LAST) begin
            accept = 1'b1;
            deb_d  = sync_q;
            down_d = ~sync_q;
            up_d   = sync_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
          meta_q <= IDLE;
          sync_q <= IDLE;
          deb_q  <= IDLE;
          cnt_q  <= '0;
          down_q <= 1'b0;
          up_q   <= 1'b0;
        end else begin
          meta_q <= i_Button[gi];
          sync_q <= meta_q;
          deb_q  <= deb_d;
          cnt_q  <= cnt_d;
          down_q <= down_d;
          up_q   <= up_d;
        end
      end

      assign o_ButtonDeb[gi]  = deb_q;
      assign o_ButtonDown[gi] = down_q;
      assign o_ButtonUp[gi]   = up_q;

      if (REPEAT_EN != 0) begin : g_rep
        localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
        localparam int REP_W   = $clog2(REP_MAX + 1);
        localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
        localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE - 1);

        logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
        logic             rep_phase_q, rep_phase_d;
        logic             rep_q, rep_d;

        // Phase 0 waits out the initial delay, phase 1 runs at the repeat rate;
        // any accepted edge (press or release) restarts from phase 0.
        always_comb begin
          rep_cnt_d   = rep_cnt_q;
          rep_phase_d = rep_phase_q;
          rep_d       = 1'b0;
          if (accept || (deb_q != PRESS)) begin
            rep_cnt_d   = '0;
            rep_phase_d = 1'b0;
          end else if (rep_cnt_q == (rep_phase_q ? RATE_LAST : DELAY_LAST)) begin
            rep_d       = 1'b1;
            rep_cnt_d   = '0;
            rep_phase_d = 1'b1;
          end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
          end
        end

        always_ff @(posedge i_Clk or posedge i_Reset) begin
          if (i_Reset) begin
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b0;
            rep_q       <= 1'b0;
          end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_phase_q <= rep_phase_d;
            rep_q       <= rep_d;
          end
        end

        assign o_Repeat[gi] = rep_q;
      end else begin : g_norep
        assign o_Repeat[gi] = 1'b0;
      end
    end
  endgenerate

endmodule

// File: tb/tb_button_bank_debouncer.sv
// Directed bench for button_bank_debouncer: 2 channels, 4-tick filter, repeat 10/3, active-low press.
module tb_button_bank_debouncer;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn;
  logic [1:0] deb, down, up, rep;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  button_bank_debouncer #(
    .CHANNELS(2), .STABLE_TICKS(4), .PRESS_LEVEL(0),
    .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_RATE(3)
  ) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Button(btn),
    .o_ButtonDeb(deb), .o_ButtonDown(down), .o_ButtonUp(up), .o_Repeat(rep)
  );

  typedef struct {
    logic [1:0] btn;
    int         n;
    logic [1:0] deb, down, up, rep;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [1:0] b, input int n, input logic [1:0] d,
                     input logic [1:0] dn, input logic [1:0] u, input logic [1:0] r);
    vec_t v;
    v.btn = b; v.n = n; v.deb = d; v.down = dn; v.up = u; v.rep = r;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] exp);
    total++;
    if ({deb, down, up, rep} !== exp) begin
      bad++;
      $display("FAIL %s t=%0t deb/down/up/rep got=%b required=%b", name, $time,
               {deb, down, up, rep}, exp);
    end
  endtask

  // Apply raw input, let one rising edge pass, return at the falling edge.
  task automatic cyc(input logic [1:0] b);
    btn = b;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    btn = 2'b11;
    repeat (3) @(negedge clk);
    check("reset_state", 8'b11_00_00_00);
    rst = 1'b0;

    // Press ch0, auto-repeat, release mid-rate (repeat due at release edge is suppressed).
    add(2'b10, 5, 2'b11, 2'b00, 2'b00, 2'b00);
    add(2'b10, 1, 2'b10, 2'b01, 2'b00, 2'b00);
    add(2'b10, 9, 2'b10, 2'b00, 2'b00, 2'b00);
    add(2'b10, 1, 2'b10, 2'b00, 2'b00, 2'b01);
    add(2'b10, 2, 2'b10, 2'b00, 2'b00, 2'b00);
    add(2'b10, 1, 2'b10, 2'b00, 2'b00, 2'b01);
    add(2'b10, 2, 2'b10, 2'b00, 2'b00, 2'b00);
    add(2'b10, 1, 2'b10, 2'b00, 2'b00, 2'b01);
    add(2'b10, 2, 2'b10, 2'b00, 2'b00, 2'b00);
    add(2'b10, 1, 2'b10, 2'b00, 2'b00, 2'b01);
    add(2'b11, 2, 2'b10, 2'b00, 2'b00, 2'b00);
    add(2'b11, 1, 2'b10, 2'b00, 2'b00, 2'b01);
    add(2'b11, 2, 2'b10, 2'b00, 2'b00, 2'b00);
    add(2'b11, 1, 2'b11, 2'b00, 2'b01, 2'b00);
    add(2'b11, 12, 2'b11, 2'b00, 2'b00, 2'b00);
    // Glitches: 3-edge low, then 3 low / 1 high / 3 low never reach 4 in a row.
    add(2'b10, 3, 2'b11, 2'b00, 2'b00, 2'b00);
    add(2'b11, 6, 2'b11, 2'b00, 2'b00, 2'b00);
    add(2'b10, 3, 2'b11, 2'b00, 2'b00, 2'b00);
    add(2'b11, 1, 2'b11, 2'b00, 2'b00, 2'b00);
    add(2'b10, 3, 2'b11, 2'b00, 2'b00, 2'b00);
    add(2'b11, 8, 2'b11, 2'b00, 2'b00, 2'b00);
    // Both channels together: simultaneous down, repeat, up.
    add(2'b00, 5, 2'b11, 2'b00, 2'b00, 2'b00);
    add(2'b00, 1, 2'b00, 2'b11, 2'b00, 2'b00);
    add(2'b00, 9, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b00, 1, 2'b00, 2'b00, 2'b00, 2'b11);
    add(2'b11, 2, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b11, 1, 2'b00, 2'b00, 2'b00, 2'b11);
    add(2'b11, 2, 2'b00, 2'b00, 2'b00, 2'b00);
    add(2'b11, 1, 2'b11, 2'b00, 2'b11, 2'b00);
    add(2'b11, 5, 2'b11, 2'b00, 2'b00, 2'b00);

    for (int i = 0; i < tbl.size(); i++) begin
      $display("vec %0d btn=%b cycles=%0d expect deb=%b down=%b up=%b rep=%b",
               i, tbl[i].btn, tbl[i].n, tbl[i].deb, tbl[i].down, tbl[i].up, tbl[i].rep);
      for (int k = 0; k < tbl[i].n; k++) begin
        cyc(tbl[i].btn);
        check($sformatf("vec%0d_cyc%0d", i, k),
              {tbl[i].deb, tbl[i].down, tbl[i].up, tbl[i].rep});
      end
    end

    // Reset mid-count (counter at 2) aborts silently; idle release gives no pulse.
    $display("seq reset_mid_count");
    repeat (4) cyc(2'b10);
    rst = 1'b1;
    btn = 2'b11;
    #1;
    check("rst_mid_count_async", 8'b11_00_00_00);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc(2'b11);
      check($sformatf("rst_idle_cyc%0d", k), 8'b11_00_00_00);
    end

    // Reset while held pressed: level returns to idle with no Up pulse.
    $display("seq reset_mid_hold");
    for (int k = 1; k <= 9; k++) begin
      cyc(2'b10);
      if (k == 6) check("hold_press_down", 8'b10_01_00_00);
    end
    rst = 1'b1;
    btn = 2'b11;
    #1;
    check("rst_mid_hold_async", 8'b11_00_00_00);
    @(negedge clk);
    check("rst_mid_hold_held", 8'b11_00_00_00);

    // Release reset with ch1 already pressed: accepted as a normal press after edge 6.
    $display("seq release_with_ch1_pressed");
    btn = 2'b01;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      cyc(2'b01);
      check($sformatf("rel_press_edge%0d", k),
            {(k >= 6) ? 2'b01 : 2'b11, (k == 6) ? 2'b10 : 2'b00, 2'b00, 2'b00});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
